opt_sched: RTL and testbench

OPT_SCHED -- requirements
Module: opt_sched

---
 rtl/opt_sched.sv | 151 +++++++++++++++
 tb/tb_opt_sched.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/opt_sched.sv
// rtl/opt_sched.sv - round-robin descriptor scheduler for the route-pass datapath
module opt_sched #(
    parameter int N_REQ    = 4,
    parameter int CITY_DIV = 16,
    parameter int WDOG     = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*3-1:0]   req_cmd,
    input  logic [N_REQ*7-1:0]   req_k,
    input  logic [N_REQ*7-1:0]   req_l,
    output logic [N_REQ-1:0]     req_ready,
    output logic [2:0]           dp_cmd,
    output logic [6:0]           dp_k,
    output logic [6:0]           dp_l,
    output logic                 dp_start,
    output logic                 dp_busy,
    input  logic                 dp_beat_valid,
    output logic [N_REQ-1:0]     done,
    output logic                 err,
    output logic                 stray
);
    localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BW   = (CITY_DIV > 1) ? $clog2(CITY_DIV) : 1;
    localparam int IW   = $clog2(WDOG + 1);
    localparam int KMAX = CITY_DIV * 8;

    localparam logic [2:0] CMD_OR0 = 3'd1;
    localparam logic [2:0] CMD_OR1 = 3'd2;
    localparam logic [2:0] CMD_TWO = 3'd3;
    localparam logic [2:0] CMD_THR = 3'd4;

    typedef enum logic [1:0] {IDLE, ISSUE, RUN, FIN} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_ptr, owner, win, rr_next;
    logic            found, grant, legal, beat_last, timeout;
    logic [2:0]      win_cmd;
    logic [6:0]      win_k, win_l;
    logic [BW-1:0]   beat_cnt;
    logic [IW-1:0]   idle_cnt;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_valid[(int'(rr_ptr) + i) % N_REQ]) begin
                found = 1'b1;
                win   = PW'((int'(rr_ptr) + i) % N_REQ);
            end
        end
    end

    assign win_cmd = req_cmd[int'(win)*3 +: 3];
    assign win_k   = req_k[int'(win)*7 +: 7];
    assign win_l   = req_l[int'(win)*7 +: 7];
    assign rr_next = (int'(win) == N_REQ - 1) ? '0 : win + PW'(1);

    // Legality of the winning descriptor: command range, city range, K/L ordering
    always_comb begin
        legal = 1'b0;
        if (int'(win_k) < KMAX && int'(win_l) < KMAX) begin
            case (win_cmd)
                CMD_OR0: legal = (win_k < win_l);
                CMD_OR1: legal = (win_l < win_k);
                CMD_TWO: legal = (({1'b0, win_k} + 8'd1) < {1'b0, win_l});
                CMD_THR: legal = 1'b1;
                default: legal = 1'b0;
            endcase
        end
    end

    // Grants only from IDLE; gating with reset keeps req_ready low while reset is held
    assign grant     = reset && (state_q == IDLE) && found;
    assign beat_last = (state_q == RUN) && dp_beat_valid && (beat_cnt == BW'(CITY_DIV - 1));
    assign timeout   = (state_q == RUN) && !dp_beat_valid && (idle_cnt == IW'(WDOG - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and pass-control outputs
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        done      = '0;
        dp_start  = 1'b0;
        dp_busy   = 1'b0;
        if (grant) req_ready[win] = 1'b1;
        case (state_q)
            IDLE: begin
                if (grant && legal) state_d = ISSUE;
            end
            ISSUE: begin
                dp_start = 1'b1;
                dp_busy  = 1'b1;
                state_d  = RUN;
            end
            RUN: begin
                dp_busy = 1'b1;
                if (beat_last)    state_d = FIN;
                else if (timeout) state_d = IDLE;
            end
            FIN: begin
                done[owner] = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Descriptor latch, round-robin pointer, beat/idle counters, err and stray flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr   <= '0;
            owner    <= '0;
            dp_cmd   <= '0;
            dp_k     <= '0;
            dp_l     <= '0;
            beat_cnt <= '0;
            idle_cnt <= '0;
            err      <= 1'b0;
            stray    <= 1'b0;
        end else begin
            err <= (grant && !legal) || timeout;
            if (dp_beat_valid && state_q != RUN) stray <= 1'b1;
            if (grant) rr_ptr <= rr_next;
            if (grant && legal) begin
                dp_cmd <= win_cmd;
                dp_k   <= win_k;
                dp_l   <= win_l;
                owner  <= win;
            end
            if (state_q == ISSUE) begin
                beat_cnt <= '0;
                idle_cnt <= '0;
            end else if (state_q == RUN) begin
                if (dp_beat_valid) begin
                    beat_cnt <= beat_cnt + BW'(1);
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + IW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_opt_sched.sv
// tb/tb_opt_sched.sv - self-checking bench for opt_sched
module tb_opt_sched;
    localparam int N  = 4;
    localparam int CD = 16;
    localparam int WD = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*3-1:0] req_cmd;
    logic [N*7-1:0] req_k, req_l;
    logic [N-1:0]   req_ready, done;
    logic [2:0]     dp_cmd;
    logic [6:0]     dp_k, dp_l;
    logic           dp_start, dp_busy, dp_beat_valid, err, stray;

    always #5 clk = ~clk;

    opt_sched #(.N_REQ(N), .CITY_DIV(CD), .WDOG(WD)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_cmd(req_cmd),
        .req_k(req_k), .req_l(req_l), .req_ready(req_ready), .dp_cmd(dp_cmd),
        .dp_k(dp_k), .dp_l(dp_l), .dp_start(dp_start), .dp_busy(dp_busy),
        .dp_beat_valid(dp_beat_valid), .done(done), .err(err), .stray(stray)
    );

    typedef struct {
        int req;
        int cmd;
        int k;
        int l;
        bit lg;
    } vec_t;

    vec_t tbl[10];
    int   n_pass = 0;
    int   n_tot  = 0;
    int   rr     = 0;
    int   pend   = 0;
    bit   at_neg = 0;
    int   d_cmd[N], d_k[N], d_l[N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit legal(int c, int k, int l);
        if (k >= CD * 8 || l >= CD * 8) return 1'b0;
        case (c)
            1:       return k < l;
            2:       return l < k;
            3:       return k + 1 < l;
            4:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int pick(int mask);
        for (int i = 0; i < N; i++)
            if (mask[(rr + i) % N]) return (rr + i) % N;
        return -1;
    endfunction

    task automatic post(input int r, input int c, input int k, input int l);
        if (at_neg) begin
            @(posedge clk); #1;
            at_neg = 0;
        end
        d_cmd[r] = c; d_k[r] = k; d_l[r] = l;
        req_cmd[r*3 +: 3] = 3'(c);
        req_k[r*7 +: 7]   = 7'(k);
        req_l[r*7 +: 7]   = 7'(l);
        req_valid[r]      = 1'b1;
        pend |= (1 << r);
    endtask

    task automatic serve(input int w, input bit lg, input int gapmax);
        int gap;
        int exp_desc;
        if (!at_neg) @(negedge clk);
        at_neg = 0;
        chk("grant", req_ready, 1 << w);
        @(posedge clk); #1;
        req_valid[w] = 1'b0;
        pend &= ~(1 << w);
        rr = (w + 1) % N;
        @(negedge clk);
        chk("dp_start", dp_start, lg);
        chk("err_after_grant", err, !lg);
        if (!lg) begin
            at_neg = 1;
            return;
        end
        exp_desc = (d_cmd[w] << 14) | (d_k[w] << 7) | d_l[w];
        chk("busy_issue", dp_busy, 1);
        chk("dp_desc", {dp_cmd, dp_k, dp_l}, exp_desc);
        @(posedge clk); #1;
        for (int b = 0; b < CD; b++) begin
            gap = (gapmax > 0) ? $urandom_range(0, gapmax) : 0;
            repeat (gap) begin
                @(posedge clk); #1;
            end
            dp_beat_valid = 1'b1;
            @(posedge clk); #1;
            dp_beat_valid = 1'b0;
        end
        @(negedge clk);
        chk("done", done, 1 << w);
        chk("busy_at_done", dp_busy, 0);
        chk("desc_stable", {dp_cmd, dp_k, dp_l}, exp_desc);
        @(posedge clk); #1;
        chk("done_once", done, 0);
    endtask

    task automatic drain(input int gapmax);
        int w;
        while (pend != 0) begin
            w = pick(pend);
            serve(w, legal(d_cmd[w], d_k[w], d_l[w]), gapmax);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        req_valid = '0; dp_beat_valid = 1'b0;
        pend = 0; rr = 0; at_neg = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Hard time limit so a stuck design still ends the run
    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n;
        bit seen, busy_ok;
        tbl[0] = '{0, 1, 3, 20, 1'b1};
        tbl[1] = '{1, 1, 20, 3, 1'b0};
        tbl[2] = '{2, 2, 40, 5, 1'b1};
        tbl[3] = '{3, 2, 5, 5, 1'b0};
        tbl[4] = '{0, 3, 10, 12, 1'b1};
        tbl[5] = '{1, 3, 10, 11, 1'b0};
        tbl[6] = '{2, 4, 90, 90, 1'b1};
        tbl[7] = '{3, 0, 1, 2, 1'b0};
        tbl[8] = '{0, 7, 1, 2, 1'b0};
        tbl[9] = '{1, 4, 127, 0, 1'b1};

        reset = 1'b0;
        req_valid = '1;
        req_cmd = {N{3'd4}};
        req_k = '0;
        req_l = '0;
        dp_beat_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_outs", {done, err, dp_start, dp_busy, stray, dp_cmd, dp_k, dp_l}, 0);
        req_valid = '0;
        dp_beat_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            post(tbl[i].req, tbl[i].cmd, tbl[i].k, tbl[i].l);
            serve(tbl[i].req, tbl[i].lg, 0);
        end

        do_reset();
        for (int r = 0; r < N; r++) post(r, 4, $urandom_range(0, 127), $urandom_range(0, 127));
        drain(0);
        post(0, 4, 33, 2);
        drain(0);

        post(2, 3, 10, 11);
        drain(0);
        for (int r = 0; r < N; r++) post(r, 4, r, 100 - r);
        drain(1);

        post(1, 2, 40, 5);
        @(negedge clk);
        chk("wd_grant", req_ready, 2);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        pend = 0;
        rr = 2;
        @(negedge clk);
        chk("wd_start", dp_start, 1);
        @(posedge clk); #1;
        repeat (7) begin
            dp_beat_valid = 1'b1;
            @(posedge clk); #1;
        end
        dp_beat_valid = 1'b0;
        n = 0; seen = 0; busy_ok = 1;
        while (n < 100 && !seen) begin
            @(negedge clk);
            n++;
            if (err) seen = 1;
            else begin
                if (!dp_busy) busy_ok = 0;
                @(posedge clk); #1;
            end
        end
        chk("wd_cycles", n, 65);
        chk("wd_busy_held", busy_ok, 1);
        chk("wd_busy_drop", dp_busy, 0);
        chk("wd_no_done", done, 0);
        at_neg = 1;
        post(3, 1, 2, 9);
        drain(0);

        for (int round = 0; round < 25; round++) begin
            int mask;
            mask = $urandom_range(1, (1 << N) - 1);
            for (int r = 0; r < N; r++)
                if (mask[r]) post(r, $urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 127));
            drain(3);
        end

        if (at_neg) begin
            @(posedge clk); #1;
            at_neg = 0;
        end
        chk("stray_clear", stray, 0);
        dp_beat_valid = 1'b1;
        @(posedge clk); #1;
        dp_beat_valid = 1'b0;
        @(negedge clk);
        chk("stray_set", stray, 1);
        @(posedge clk); #1;
        post(1, 4, 1, 1);
        drain(0);
        chk("stray_sticky", stray, 1);

        post(0, 1, 3, 20);
        @(negedge clk);
        chk("mid_grant", req_ready, 1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        repeat (7) begin
            dp_beat_valid = 1'b1;
            @(posedge clk); #1;
        end
        dp_beat_valid = 1'b1;
        chk("mid_busy", dp_busy, 1);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_busy", dp_busy, 0);
        chk("mid_rst_outs", {req_ready, done, err, dp_start, stray, dp_cmd, dp_k, dp_l}, 0);
        dp_beat_valid = 1'b0;
        pend = 0; rr = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("post_rst_err", err, 0);
        post(2, 4, 5, 6);
        post(0, 4, 7, 8);
        drain(0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
